// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester round-robin arbiter in front of a single memory port.
//   A granted request is latched into registered command outputs and issued
//   with a valid/ready handshake. A wait counter bounds how long the command
//   waits for the memory. The requester then sees a one-cycle completion
//   pulse, or a one-cycle error pulse if the wait ran out.
//
// Ports
//   clk      : clock, all logic on the rising edge
//   rst      : asynchronous active-high reset
//   r_valid  : [1:0] per-requester request, held until r_done/r_err
//   r_wr_rd  : [1:0] per-requester direction (1 = write, 0 = read)
//   r_addr   : [2*ADDR_WIDTH-1:0] requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   r_wdata  : [2*WIDTH-1:0] requester i at [i*WIDTH +: WIDTH]
//   r_done   : [1:0] one-cycle completion pulse for the granted requester
//   r_err    : [1:0] one-cycle timeout pulse for the granted requester
//   r_rdata  : [WIDTH-1:0] data from the most recent completed read
//   m_valid, m_wr_rd, m_addr, m_wdata : registered memory command
//   m_ready  : memory accepts the command
//   m_rdata  : [WIDTH-1:0] memory read data, valid with m_ready
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              r_valid,
  input  logic [1:0]              r_wr_rd,
  input  logic [2*ADDR_WIDTH-1:0] r_addr,
  input  logic [2*WIDTH-1:0]      r_wdata,
  output logic [1:0]              r_done,
  output logic [1:0]              r_err,
  output logic [WIDTH-1:0]        r_rdata,
  output logic                    m_valid,
  output logic                    m_wr_rd,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [WIDTH-1:0]        m_wdata,
  input  logic                    m_ready,
  input  logic [WIDTH-1:0]        m_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Last wait-counter value at which the command is still allowed to wait,
  // so m_valid stays up for exactly TIMEOUT cycles before giving up.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic       grant;
  logic       last_grant;
  logic       err_flag;
  logic [7:0] wait_cnt;
  logic       pick;

  // Round-robin choice: under contention the requester that did not win
  // last time gets the grant.
  always_comb begin
    pick = 1'b0;
    if (r_valid == 2'b11)
      pick = ~last_grant;
    else if (r_valid[1])
      pick = 1'b1;
  end

  // The pulses are decoded from the DONE state, so an asynchronous reset
  // kills them immediately, together with the in-flight transaction.
  assign r_done = (state == DONE && !err_flag) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign r_err  = (state == DONE &&  err_flag) ? (grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      err_flag   <= 1'b0;
      wait_cnt   <= 8'd0;
      m_valid    <= 1'b0;
      m_wr_rd    <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|r_valid) begin
            grant    <= pick;
            m_wr_rd  <= r_wr_rd[pick];
            m_addr   <= pick ? r_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : r_addr[ADDR_WIDTH-1:0];
            m_wdata  <= pick ? r_wdata[2*WIDTH-1:WIDTH] : r_wdata[WIDTH-1:0];
            m_valid  <= 1'b1;
            wait_cnt <= 8'd0;
            err_flag <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ready) begin
            m_valid    <= 1'b0;
            last_grant <= grant;
            state      <= DONE;
            if (!m_wr_rd)
              r_rdata <= m_rdata;
          end else if (wait_cnt == WAIT_LAST) begin
            m_valid    <= 1'b0;
            err_flag   <= 1'b1;
            last_grant <= grant;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (ADDR_WIDTH = 8, WIDTH = 8, TIMEOUT = 16).
//   Each step drives inputs one time unit after a rising edge and checks the
//   outputs that belong to the cycle just entered.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  r_valid;
  logic [1:0]  r_wr_rd;
  logic [7:0]  addr0, addr1, wdata0, wdata1;
  logic [1:0]  r_done;
  logic [1:0]  r_err;
  logic [7:0]  r_rdata;
  logic        m_valid;
  logic        m_wr_rd;
  logic [7:0]  m_addr;
  logic [7:0]  m_wdata;
  logic        m_ready;
  logic [7:0]  m_rdata;

  int checks = 0;
  int errors = 0;
  int cnt;

  mem_arbiter #(.ADDR_WIDTH(8), .WIDTH(8), .TIMEOUT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .r_valid (r_valid),
    .r_wr_rd (r_wr_rd),
    .r_addr  ({addr1, addr0}),
    .r_wdata ({wdata1, wdata0}),
    .r_done  (r_done),
    .r_err   (r_err),
    .r_rdata (r_rdata),
    .m_valid (m_valid),
    .m_wr_rd (m_wr_rd),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ready (m_ready),
    .m_rdata (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; r_valid = 2'b00; r_wr_rd = 2'b00;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
    m_ready = 1'b0; m_rdata = 8'h00;

    // Reset values
    tick();
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_addr",  32'(m_addr),  32'h0);
    check("rst_m_wdata", 32'(m_wdata), 32'h0);
    check("rst_m_wr_rd", 32'(m_wr_rd), 32'h0);
    check("rst_r_done",  32'(r_done),  32'h0);
    check("rst_r_err",   32'(r_err),   32'h0);
    check("rst_r_rdata", 32'(r_rdata), 32'h0);
    rst = 1'b0;

    // Single write, memory always ready (m_ready high in IDLE is ignored)
    m_ready = 1'b1;
    tick();
    check("idle_ready_ignored", 32'(m_valid), 32'h0);
    r_valid = 2'b01; r_wr_rd = 2'b01; addr0 = 8'h10; wdata0 = 8'hA5;
    tick();
    check("wr_m_valid", 32'(m_valid), 32'h1);
    check("wr_m_addr",  32'(m_addr),  32'h10);
    check("wr_m_wdata", 32'(m_wdata), 32'hA5);
    check("wr_m_wr_rd", 32'(m_wr_rd), 32'h1);
    check("wr_no_done_yet", 32'(r_done), 32'h0);
    tick();
    check("wr_m_valid_drop", 32'(m_valid), 32'h0);
    check("wr_r_done", 32'(r_done), 32'h1);
    check("wr_r_err",  32'(r_err),  32'h0);
    r_valid = 2'b00;
    tick();
    check("wr_done_one_cycle", 32'(r_done), 32'h0);

    // Requester 1 read, memory ready only in the third ISSUE cycle
    m_ready = 1'b0;
    r_valid = 2'b10; r_wr_rd = 2'b00; addr1 = 8'h20;
    tick();
    check("rd_c1_m_valid", 32'(m_valid), 32'h1);
    check("rd_c1_m_addr",  32'(m_addr),  32'h20);
    check("rd_c1_m_wr_rd", 32'(m_wr_rd), 32'h0);
    addr1 = 8'h77; r_wr_rd = 2'b10;
    tick();
    check("rd_c2_m_valid", 32'(m_valid), 32'h1);
    tick();
    check("rd_c3_m_valid", 32'(m_valid), 32'h1);
    check("rd_c3_addr_stable", 32'(m_addr), 32'h20);
    check("rd_c3_dir_stable",  32'(m_wr_rd), 32'h0);
    m_ready = 1'b1; m_rdata = 8'h5A;
    tick();
    check("rd_r_done",  32'(r_done),  32'h2);
    check("rd_r_rdata", 32'(r_rdata), 32'h5A);
    check("rd_m_valid_drop", 32'(m_valid), 32'h0);
    r_valid = 2'b00; m_ready = 1'b0; m_rdata = 8'h00; r_wr_rd = 2'b00;
    tick();
    check("rd_done_cleared", 32'(r_done), 32'h0);
    check("rd_rdata_held",   32'(r_rdata), 32'h5A);

    // Timeout: memory never ready
    r_valid = 2'b01; r_wr_rd = 2'b00; addr0 = 8'h30;
    tick();
    cnt = 0;
    while (m_valid === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check("to_valid_cycles", 32'(cnt), 32'd16);
    check("to_r_err",  32'(r_err),  32'h1);
    check("to_r_done", 32'(r_done), 32'h0);
    check("to_rdata_unchanged", 32'(r_rdata), 32'h5A);
    r_valid = 2'b00;
    tick();
    check("to_err_cleared", 32'(r_err), 32'h0);

    // Next request after timeout: write 0x3C, read data must not move
    m_ready = 1'b1;
    r_valid = 2'b01; r_wr_rd = 2'b01; addr0 = 8'h40; wdata0 = 8'h3C;
    tick();
    check("wr2_m_wdata", 32'(m_wdata), 32'h3C);
    tick();
    check("wr2_r_done", 32'(r_done), 32'h1);
    check("wr2_rdata_held", 32'(r_rdata), 32'h5A);
    r_valid = 2'b00;
    tick();

    // Read from requester 0 updates r_rdata
    r_valid = 2'b01; r_wr_rd = 2'b00; addr0 = 8'h44; m_rdata = 8'hC3;
    tick();
    check("rd2_m_addr", 32'(m_addr), 32'h44);
    tick();
    check("rd2_r_done",  32'(r_done),  32'h1);
    check("rd2_r_rdata", 32'(r_rdata), 32'hC3);
    r_valid = 2'b00;
    tick();

    // Reset in the second ISSUE cycle
    m_ready = 1'b0;
    r_valid = 2'b01; addr0 = 8'h48;
    tick();
    check("rstmid_c1_valid", 32'(m_valid), 32'h1);
    tick();
    check("rstmid_c2_valid", 32'(m_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("rstmid_async_drop", 32'(m_valid), 32'h0);
    check("rstmid_no_done", 32'(r_done), 32'h0);
    check("rstmid_no_err",  32'(r_err),  32'h0);
    tick();
    check("rstmid_hold_done", 32'(r_done | r_err), 32'h0);
    r_valid = 2'b00;
    rst = 1'b0;

    // Contention from reset: grants alternate 0,1,0,1
    m_ready = 1'b1;
    r_valid = 2'b11; r_wr_rd = 2'b00; addr0 = 8'h50; addr1 = 8'h60;
    for (int i = 0; i < 4; i++) begin
      m_rdata = 8'h80 + 8'(i);
      tick();
      check("ct_m_valid", 32'(m_valid), 32'h1);
      check("ct_m_addr", 32'(m_addr), (i % 2 == 0) ? 32'h50 : 32'h60);
      check("ct_no_done_in_issue", 32'(r_done), 32'h0);
      tick();
      check("ct_r_done", 32'(r_done), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("ct_r_rdata", 32'(r_rdata), 32'h80 + 32'(i));
      check("ct_m_valid_gap", 32'(m_valid), 32'h0);
      tick();
      check("ct_done_cleared", 32'(r_done), 32'h0);
      check("ct_idle_gap", 32'(m_valid), 32'h0);
    end
    r_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
